wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_arbiter_if                                                |
// | Description : Writeback port bundle: ALU result, LSU result, register-file |
// |               write and LSU buffer occupancy.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface wb_arbiter_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  logic                   alu_valid;
  logic [4:0]             alu_rd;
  logic [XLEN-1:0]        alu_data;
  logic                   alu_stall;
  logic                   lsu_valid;
  logic                   lsu_ready;
  logic [4:0]             lsu_rd;
  logic [XLEN-1:0]        lsu_data;
  logic                   reg_write;
  logic [4:0]             write_addr;
  logic [XLEN-1:0]        write_data;
  logic [$clog2(DEPTH):0] lsu_pending;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_stall, lsu_ready, reg_write, write_addr, write_data, lsu_pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_stall, lsu_ready, reg_write, write_addr, write_data, lsu_pending
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_arbiter                                                   |
// | Description : Single-port register-file writeback arbiter. ALU results win |
// |               the port; LSU results queue in a FIFO and drain when free.   |
// |               Define WB_STARVE_GUARD_EN to add the FIFO starvation guard.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  wb_arbiter_if.slave bus
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
    $error("wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic [4:0]         ent_rd_q   [DEPTH];
  logic [4:0]         ent_rd_d   [DEPTH];
  logic [XLEN-1:0]    ent_data_q [DEPTH];
  logic [XLEN-1:0]    ent_data_d [DEPTH];
  logic               reg_write_q, reg_write_d;
  logic [4:0]         write_addr_q, write_addr_d;
  logic [XLEN-1:0]    write_data_q, write_data_d;

  logic fifo_empty;
  logic lsu_ready;
  logic alu_stall;
  logic alu_write;
  logic push;
  logic pop;

  // Ready ignores a same-cycle pop so it never depends on the ALU inputs.
  always_comb begin
    fifo_empty = (count_q == '0);
    lsu_ready  = rst_n && (count_q < c_FULL);
    alu_write  = bus.alu_valid && !alu_stall && (bus.alu_rd != 5'd0);
    pop        = !fifo_empty && !alu_write;
    push       = bus.lsu_valid && lsu_ready && (bus.lsu_rd != 5'd0);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    if (push) begin
      ent_rd_d[wr_ptr_q]   = bus.lsu_rd;
      ent_data_d[wr_ptr_q] = bus.lsu_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Address and data hold their last values when nothing is selected.
  always_comb begin
    reg_write_d  = alu_write || pop;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (alu_write) begin
      write_addr_d = bus.alu_rd;
      write_data_d = bus.alu_data;
    end else if (pop) begin
      write_addr_d = ent_rd_q[rd_ptr_q];
      write_data_d = ent_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_rd_q   <= ent_rd_d;
    ent_data_q <= ent_data_d;
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

  logic [c_STV_W-1:0] starve_q, starve_d;
  logic               stall_q, stall_d;

  // The stall cycle always pops, so the counter never passes STARVE_LIMIT.
  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (!fifo_empty && alu_write) begin
      starve_d = starve_q + 1'b1;
    end
    stall_d = (starve_d == c_STV_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign alu_stall     = stall_q;
  assign bus.alu_stall = rst_n && stall_q;
`else
  assign alu_stall     = 1'b0;
  assign bus.alu_stall = 1'b0;
`endif

  assign bus.lsu_ready   = lsu_ready;
  assign bus.lsu_pending = count_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.write_addr  = write_addr_q;
  assign bus.write_data  = write_data_q;

endmodule
`default_nettype wire
